// File: rtl/vga_if.sv
// vga_if: one VGA layer bundle (12-bit rgb plus 11-bit counters, sync and blank flags)
// Ports: none; modports in/slave sample a layer, out/master drive one.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;
  modport in     (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport out    (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport slave  (input  vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
  modport master (output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb);
endinterface

// File: rtl/screen_sequencer.sv
// screen_sequencer: picks the menu/game/win layer for VGA output, switching only at frame boundaries
// Ports: clk, rst (async, active high); start_btn, p1_win, p2_win event pulses;
//   menu_in (also timing reference), game_in, fp_in, sp_in layers; vga_out registered layer;
//   scr_state current screen (0 MENU, 1 PLAY, 2 P1_WON, 3 P2_WON).
// Option: define SCREEN_BLINK_EN to blank the win screens every other BLINK_FRAMES frames.
module screen_sequencer #(
  parameter int WIN_FRAMES   = 180,
  parameter int BLINK_FRAMES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       p1_win,
  input  logic       p2_win,
  vga_if.in          menu_in,
  vga_if.in          game_in,
  vga_if.in          fp_in,
  vga_if.in          sp_in,
  vga_if.out         vga_out,
  output logic [1:0] scr_state
);
  typedef enum logic [1:0] {MENU, PLAY, P1_WON, P2_WON} state_t;
  localparam logic [7:0] WIN_LAST = 8'(WIN_FRAMES - 1);
  state_t      state_q, state_d;
  logic        start_pend_q, start_pend_d;
  logic        win_pend_q, win_pend_d;
  logic        win_who_q, win_who_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        vblnk_q;
  logic [25:0] tim_q, tim_d;
  logic [11:0] rgb_q, rgb_d;
  logic        fb;
  logic        dark;
  assign fb = menu_in.vblnk & ~vblnk_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MENU;
      start_pend_q <= 1'b0;
      win_pend_q   <= 1'b0;
      win_who_q    <= 1'b0;
      cnt_q        <= '0;
      vblnk_q      <= 1'b0;
      tim_q        <= '0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      win_pend_q   <= win_pend_d;
      win_who_q    <= win_who_d;
      cnt_q        <= cnt_d;
      vblnk_q      <= menu_in.vblnk;
      tim_q        <= tim_d;
      rgb_q        <= rgb_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MENU: state_d = (fb && start_pend_q) ? PLAY : MENU;
      PLAY: if (fb && win_pend_q) begin
        state_d = win_who_q ? P2_WON : P1_WON;
        cnt_d   = '0;
      end
      default: if (fb) begin
        state_d = (cnt_q == WIN_LAST) ? MENU : state_q;
        cnt_d   = (cnt_q == WIN_LAST) ? '0 : cnt_q + 8'd1;
      end
    endcase
    // Pending flags only live while their state holds, so nothing stale survives a transition.
    start_pend_d = (state_q == MENU) && (state_d == MENU) && (start_pend_q || start_btn);
    win_pend_d   = (state_q == PLAY) && (state_d == PLAY) && (win_pend_q || p1_win || p2_win);
    win_who_d    = (state_q == PLAY && !win_pend_q && (p1_win || p2_win)) ? ~p1_win : win_who_q;
  end
`ifdef SCREEN_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  logic       blink_q, blink_d;
  logic [7:0] bcnt_q, bcnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end
  // Held at zero outside the win states so each win screen starts in the visible phase.
  always_comb begin
    bcnt_d  = !state_q[1] ? '0 : (fb ? ((bcnt_q == BLINK_LAST) ? '0 : bcnt_q + 8'd1) : bcnt_q);
    blink_d = state_q[1] && (blink_q ^ (fb && bcnt_q == BLINK_LAST));
  end
  assign dark = state_q[1] & blink_q;
`else
  assign dark = 1'b0;
`endif
  always_comb begin
    tim_d = {menu_in.vcount, menu_in.vsync, menu_in.vblnk, menu_in.hcount, menu_in.hsync, menu_in.hblnk};
    rgb_d = dark ? 12'h000 :
            (state_q == MENU)   ? menu_in.rgb :
            (state_q == PLAY)   ? game_in.rgb :
            (state_q == P1_WON) ? fp_in.rgb : sp_in.rgb;
  end
  assign {vga_out.vcount, vga_out.vsync, vga_out.vblnk, vga_out.hcount, vga_out.hsync, vga_out.hblnk} = tim_q;
  assign vga_out.rgb = rgb_q;
  assign scr_state   = state_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: randomized and directed checks of screen_sequencer against a frame-level model
module tb_screen_sequencer;
`ifdef SCREEN_BLINK_EN
  localparam int WF = 6;
`else
  localparam int WF = 4;
`endif
  localparam int BF = 2;
  localparam int H  = 16;
  localparam int V  = 12;
  localparam int VB = 10;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       p1_win = 1'b0;
  logic       p2_win = 1'b0;
  logic [1:0] scr_state;
  vga_if menu_in();
  vga_if game_in();
  vga_if fp_in();
  vga_if sp_in();
  vga_if vga_out();
  always #5 clk = ~clk;
  screen_sequencer #(.WIN_FRAMES(WF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .p1_win(p1_win), .p2_win(p2_win),
    .menu_in(menu_in), .game_in(game_in), .fp_in(fp_in), .sp_in(sp_in),
    .vga_out(vga_out), .scr_state(scr_state)
  );
  int tests = 0;
  int fails = 0;
  int h = 0;
  int v = 0;
  int m_scr = 0;
  bit m_start = 0;
  int m_win = 0;
  int m_frames = 0;
  bit m_vb = 0;
  bit m_fb = 0;
  logic [25:0] e_tim = '0;
  logic [11:0] e_rgb = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [25:0] tim_of(input int hh, input int vv);
    return {11'(vv), vv == V - 1, vv >= VB, 11'(hh), hh == 13 || hh == 14, hh >= 12};
  endfunction
  function automatic logic [25:0] out_tim();
    return {vga_out.vcount, vga_out.vsync, vga_out.vblnk, vga_out.hcount, vga_out.hsync, vga_out.hblnk};
  endfunction
  task automatic tick(input bit s = 0, input bit a = 0, input bit b = 0);
    logic [11:0] lr [4];
    logic [25:0] t;
    int blk;
    start_btn = s;
    p1_win = a;
    p2_win = b;
    t = tim_of(h, v);
    {menu_in.vcount, menu_in.vsync, menu_in.vblnk, menu_in.hcount, menu_in.hsync, menu_in.hblnk} = t;
    {game_in.vcount, game_in.vsync, game_in.vblnk, game_in.hcount, game_in.hsync, game_in.hblnk} = t;
    {fp_in.vcount, fp_in.vsync, fp_in.vblnk, fp_in.hcount, fp_in.hsync, fp_in.hblnk} = t;
    {sp_in.vcount, sp_in.vsync, sp_in.vblnk, sp_in.hcount, sp_in.hsync, sp_in.hblnk} = t;
    for (int i = 0; i < 4; i++) lr[i] = 12'($urandom);
    menu_in.rgb = lr[0];
    game_in.rgb = lr[1];
    fp_in.rgb = lr[2];
    sp_in.rgb = lr[3];
    @(posedge clk);
    if (rst) begin
      m_scr = 0; m_start = 0; m_win = 0; m_frames = 0; m_vb = 0; m_fb = 0;
      e_tim = '0; e_rgb = '0;
    end else begin
      m_fb = (v >= VB) && !m_vb;
      blk = 0;
`ifdef SCREEN_BLINK_EN
      if (m_scr >= 2) blk = (m_frames / BF) % 2;
`endif
      e_tim = t;
      e_rgb = (blk != 0) ? 12'h000 : lr[m_scr];
      case (m_scr)
        0: if (m_fb && m_start) begin m_scr = 1; m_start = 0; end
           else if (s) m_start = 1;
        1: if (m_fb && m_win != 0) begin m_scr = m_win; m_win = 0; m_frames = 0; end
           else if (m_win == 0 && (a || b)) m_win = a ? 2 : 3;
        default: if (m_fb) begin
          m_frames++;
          if (m_frames == WF) begin m_scr = 0; m_frames = 0; end
        end
      endcase
      m_vb = v >= VB;
    end
    #1;
    chk("tim", 32'(out_tim()), 32'(e_tim));
    chk("rgb", 32'(vga_out.rgb), 32'(e_rgb));
    chk("scr", 32'(scr_state), 32'(m_scr));
    start_btn = 0; p1_win = 0; p2_win = 0;
    h++;
    if (h == H) begin h = 0; v = (v + 1) % V; end
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  task automatic run_to_fb();
    bit found = 0;
    for (int i = 0; i < 2 * H * V && !found; i++) begin
      tick();
      found = m_fb;
    end
    chk("fb_timeout", 32'(found), 1);
  endtask
  task automatic to_fb_cycle();
    for (int i = 0; i < 2 * H * V && !(v == VB && h == 0); i++) tick();
  endtask
  initial begin
    repeat (3) tick();
    rst = 0;
    chk("rst_scr", 32'(scr_state), 0);
    chk("rst_rgb", 32'(vga_out.rgb), 0);
    run(2 * H * V);
    for (int i = 0; i < H * V && !(v == 5 && h == 3); i++) tick();
    tick(1);
    run_to_fb();
    chk("start_play", 32'(scr_state), 1);
    tick();
    run(20);
    tick(0, 1, 1);
    tick(0, 0, 1);
    run_to_fb();
    chk("win_pri", 32'(scr_state), 2);
    for (int i = 0; i < WF; i++) begin
      tick(1);
      run_to_fb();
    end
    chk("p1_exit", 32'(scr_state), 0);
    tick(1);
    run_to_fb();
    tick(0, 0, 1);
    run_to_fb();
    chk("p2_enter", 32'(scr_state), 3);
    for (int i = 0; i < WF - 1; i++) begin
      tick(1);
      run_to_fb();
      chk("p2_hold", 32'(scr_state), 3);
    end
    tick(1);
    run_to_fb();
    chk("p2_exit", 32'(scr_state), 0);
    run(30);
    to_fb_cycle();
    tick(1);
    chk("coinc_stay", 32'(scr_state), 0);
    run_to_fb();
    chk("coinc_go", 32'(scr_state), 1);
    run(37);
    rst = 1;
    #2;
    chk("async_tim", 32'(out_tim()), 0);
    chk("async_rgb", 32'(vga_out.rgb), 0);
    chk("async_scr", 32'(scr_state), 0);
    tick();
    tick();
    rst = 0;
    run(H * V);
    chk("post_rst", 32'(scr_state), 0);
    for (int i = 0; i < 6000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      tick(r == 0, r == 1 || r == 3, r == 2 || r == 3);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
